// File: rtl/fetch_group_generator.sv
// fetch_group_generator: tracks the fetch PC, requests aligned instruction
// groups from imem and holds each returned group until the FIFO takes it.
module fetch_group_generator #(
   parameter int BW_PC       = 32,
   parameter int BW_INST     = 32,
   parameter int FETCH_WIDTH = 4,
   parameter int BW_PC_MOD   = $clog2(FETCH_WIDTH),
   parameter logic [BW_PC-1:0] RESET_PC = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_flush,
   input  logic [BW_PC-1:0]               i_flush_pc,
   output logic                           imem_req_valid,
   input  logic                           imem_req_ready,
   output logic [BW_PC-1:0]               imem_req_addr,
   input  logic                           imem_resp_valid,
   input  logic [FETCH_WIDTH*BW_INST-1:0] imem_resp_data,
   output logic                           o_valid,
   input  logic                           o_ready,
   output logic [FETCH_WIDTH*BW_INST-1:0] o_inst,
   output logic [BW_PC-1:0]               o_pc,
   output logic [BW_PC_MOD-1:0]           o_pc_mod_select,
   output logic [BW_PC_MOD-1:0]           o_pc_upperbound
);

   // Byte-offset bits below the group boundary.
   localparam int LO = BW_PC_MOD + 2;
   localparam int HI = BW_PC - LO;
   localparam logic [HI-1:0] HI_ONE = HI'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [BW_PC-1:0]               r_pc;
   logic [BW_PC-1:0]               w_pc_nxt;
   logic [FETCH_WIDTH*BW_INST-1:0] r_inst_q;
   logic                           w_inst_ld;
   logic [BW_PC-1:0]               w_pc_aligned;
   logic [BW_PC-1:0]               w_next_pc;
   logic [BW_PC-1:0]               w_flush_pc;
   logic [HI-1:0]                  w_pc_hi_inc;
   logic                           w_req_valid;
   logic                           w_out_valid;

   assign w_pc_aligned = {r_pc[BW_PC-1:LO], {LO{1'b0}}};
   assign w_pc_hi_inc  = r_pc[BW_PC-1:LO] + HI_ONE;
   assign w_next_pc    = {w_pc_hi_inc, {LO{1'b0}}};
   assign w_flush_pc   = {i_flush_pc[BW_PC-1:2], 2'b00};

   assign imem_req_valid  = w_req_valid;
   assign imem_req_addr   = w_pc_aligned;
   assign o_valid         = w_out_valid;
   assign o_inst          = r_inst_q;
   assign o_pc            = w_pc_aligned;
   assign o_pc_mod_select = r_pc[LO-1:2];
   assign o_pc_upperbound = BW_PC_MOD'(FETCH_WIDTH - 1);

   // State, PC and held group registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_inst_q <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_inst_ld) begin
            r_inst_q <= imem_resp_data;
         end
      end
   end

   // Next-state, PC update and handshake outputs; flush wins everywhere.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_inst_ld   = 1'b0;
      w_req_valid = 1'b0;
      w_out_valid = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
            if (i_flush) begin
               w_pc_nxt = w_flush_pc;
            end
         end
         S_REQ: begin
            w_req_valid = !i_flush;
            if (i_flush) begin
               w_pc_nxt = w_flush_pc;
            end else if (imem_req_ready) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_flush) begin
               w_pc_nxt    = w_flush_pc;
               w_state_nxt = imem_resp_valid ? S_REQ : S_DRAIN;
            end else if (imem_resp_valid) begin
               w_inst_ld   = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_DRAIN: begin
            // The squashed response still has to come back before
            // a new request may go out.
            if (i_flush) begin
               w_pc_nxt = w_flush_pc;
            end
            if (imem_resp_valid) begin
               w_state_nxt = S_REQ;
            end
         end
         S_HOLD: begin
            w_out_valid = !i_flush;
            if (i_flush) begin
               w_pc_nxt    = w_flush_pc;
               w_state_nxt = S_REQ;
            end else if (o_ready) begin
               w_pc_nxt    = w_next_pc;
               w_state_nxt = S_REQ;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // A response is only legal while one request is outstanding.
   a_resp_legal : assert property (
      @(posedge clk) disable iff (!rst)
      imem_resp_valid |-> (r_state == S_WAIT || r_state == S_DRAIN)
   );

   // A stalled group must not change under the FIFO.
   a_hold_stable : assert property (
      @(posedge clk) disable iff (!rst)
      (w_out_valid && !o_ready) |=> ($stable(r_inst_q) && $stable(w_pc_aligned))
   );

endmodule

// File: tb/tb_fetch_group_generator.sv
// tb_fetch_group_generator: cycle-by-cycle directed vectors for the
// fetch group generator, plus an asynchronous mid-run reset sequence.
module tb_fetch_group_generator;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i_flush = 1'b0;
   logic [31:0]  i_flush_pc = '0;
   logic         imem_req_valid;
   logic         imem_req_ready = 1'b0;
   logic [31:0]  imem_req_addr;
   logic         imem_resp_valid = 1'b0;
   logic [127:0] imem_resp_data = '0;
   logic         o_valid;
   logic         o_ready = 1'b0;
   logic [127:0] o_inst;
   logic [31:0]  o_pc;
   logic [1:0]   o_pc_mod_select;
   logic [1:0]   o_pc_upperbound;

   int total = 0;
   int bad   = 0;

   fetch_group_generator #(
      .RESET_PC(32'h0000_0100)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_flush         (i_flush),
      .i_flush_pc      (i_flush_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .o_valid         (o_valid),
      .o_ready         (o_ready),
      .o_inst          (o_inst),
      .o_pc            (o_pc),
      .o_pc_mod_select (o_pc_mod_select),
      .o_pc_upperbound (o_pc_upperbound)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic [31:0] fpc;
      logic        rr;
      logic        rv;
      logic        ordy;
      logic        e_rq;
      logic [31:0] e_pc;
      logic        e_ov;
      logic [1:0]  e_mod;
   } vec_t;

   vec_t tv[$];

   function automatic logic [127:0] gdata(logic [31:0] a);
      logic [127:0] d;
      for (int k = 0; k < 4; k++) begin
         d[k*32 +: 32] = (a + 32'(4 * k)) ^ 32'h5A00_0000;
      end
      return d;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic add(logic fl, logic [31:0] fpc, logic rr, logic rv,
                      logic ordy, logic e_rq, logic [31:0] e_pc,
                      logic e_ov, logic [1:0] e_mod);
      vec_t v;
      v.fl = fl; v.fpc = fpc; v.rr = rr; v.rv = rv; v.ordy = ordy;
      v.e_rq = e_rq; v.e_pc = e_pc; v.e_ov = e_ov; v.e_mod = e_mod;
      tv.push_back(v);
   endtask

   initial begin
      //   fl fpc           rr rv ordy  rq  pc            ov mod
      add(0, 32'h0,        1, 0, 1,    0, 32'h100,      0, 0); // idle
      add(0, 32'h0,        1, 0, 1,    1, 32'h100,      0, 0);
      add(0, 32'h0,        1, 1, 1,    0, 32'h100,      0, 0);
      add(0, 32'h0,        1, 0, 1,    0, 32'h100,      1, 0);
      add(0, 32'h0,        1, 0, 1,    1, 32'h110,      0, 0);
      add(0, 32'h0,        1, 1, 1,    0, 32'h110,      0, 0);
      add(0, 32'h0,        1, 0, 1,    0, 32'h110,      1, 0);
      add(0, 32'h0,        1, 0, 1,    1, 32'h120,      0, 0);
      add(0, 32'h0,        1, 1, 1,    0, 32'h120,      0, 0);
      for (int i = 0; i < 5; i++) begin                     // stall
         add(0, 32'h0,     1, 0, 0,    0, 32'h120,      1, 0);
      end
      add(0, 32'h0,        1, 0, 1,    0, 32'h120,      1, 0);
      add(0, 32'h0,        1, 0, 1,    1, 32'h130,      0, 0);
      add(0, 32'h0,        1, 1, 1,    0, 32'h130,      0, 0);
      add(1, 32'h208,      1, 0, 1,    0, 32'h130,      0, 0); // hold flush
      add(0, 32'h0,        1, 0, 1,    1, 32'h200,      0, 2);
      add(0, 32'h0,        1, 1, 1,    0, 32'h200,      0, 2);
      add(0, 32'h0,        1, 0, 1,    0, 32'h200,      1, 2);
      add(0, 32'h0,        1, 0, 1,    1, 32'h210,      0, 0);
      add(1, 32'h300,      1, 0, 1,    0, 32'h210,      0, 0); // wait flush
      add(0, 32'h0,        1, 0, 1,    0, 32'h300,      0, 0);
      add(0, 32'h0,        1, 0, 1,    0, 32'h300,      0, 0);
      add(0, 32'h0,        1, 1, 1,    0, 32'h300,      0, 0); // drained
      add(0, 32'h0,        1, 0, 1,    1, 32'h300,      0, 0);
      add(1, 32'h40C,      1, 1, 1,    0, 32'h300,      0, 0); // flush+resp
      add(0, 32'h0,        1, 0, 1,    1, 32'h400,      0, 3);
      add(0, 32'h0,        1, 1, 1,    0, 32'h400,      0, 3);
      add(0, 32'h0,        1, 0, 1,    0, 32'h400,      1, 3);
      add(1, 32'hFFFF_FFF0,1, 0, 1,    0, 32'h410,      0, 0); // req flush
      add(0, 32'h0,        0, 0, 1,    1, 32'hFFFF_FFF0,0, 0);
      add(0, 32'h0,        1, 0, 1,    1, 32'hFFFF_FFF0,0, 0);
      add(0, 32'h0,        1, 1, 1,    0, 32'hFFFF_FFF0,0, 0);
      add(0, 32'h0,        1, 0, 1,    0, 32'hFFFF_FFF0,1, 0);
      add(0, 32'h0,        0, 0, 1,    1, 32'h0,        0, 0); // wrapped
      add(0, 32'h0,        1, 0, 1,    1, 32'h0,        0, 0);
      add(1, 32'h50,       1, 0, 1,    0, 32'h0,        0, 0);
      add(1, 32'h64,       1, 0, 1,    0, 32'h50,       0, 0); // drain flush
      add(0, 32'h0,        1, 1, 1,    0, 32'h60,       0, 1);
      add(0, 32'h0,        0, 0, 1,    1, 32'h60,       0, 1);

      // Reset-state outputs.
      repeat (2) @(negedge clk);
      #2;
      chk("rst_req_valid", 128'(imem_req_valid), 128'(0));
      chk("rst_req_addr", 128'(imem_req_addr), 128'(32'h100));
      chk("rst_o_valid", 128'(o_valid), 128'(0));
      chk("rst_o_pc", 128'(o_pc), 128'(32'h100));
      chk("rst_o_inst", o_inst, 128'(0));
      chk("rst_mod_sel", 128'(o_pc_mod_select), 128'(0));
      chk("rst_upper", 128'(o_pc_upperbound), 128'(3));

      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < tv.size(); i++) begin
         i_flush         = tv[i].fl;
         i_flush_pc      = tv[i].fpc;
         imem_req_ready  = tv[i].rr;
         imem_resp_valid = tv[i].rv;
         imem_resp_data  = gdata(tv[i].e_pc);
         o_ready         = tv[i].ordy;
         #2;
         chk($sformatf("v%0d_req_valid", i),
             128'(imem_req_valid), 128'(tv[i].e_rq));
         chk($sformatf("v%0d_req_addr", i),
             128'(imem_req_addr), 128'(tv[i].e_pc));
         chk($sformatf("v%0d_o_pc", i), 128'(o_pc), 128'(tv[i].e_pc));
         chk($sformatf("v%0d_o_valid", i),
             128'(o_valid), 128'(tv[i].e_ov));
         chk($sformatf("v%0d_mod_sel", i),
             128'(o_pc_mod_select), 128'(tv[i].e_mod));
         chk($sformatf("v%0d_upper", i), 128'(o_pc_upperbound), 128'(3));
         if (tv[i].e_ov) begin
            chk($sformatf("v%0d_o_inst", i), o_inst, gdata(tv[i].e_pc));
         end
         @(negedge clk);
      end

      // Asynchronous reset mid-operation, then restart from RESET_PC.
      i_flush         = 1'b0;
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk("mrst_req_valid", 128'(imem_req_valid), 128'(0));
      chk("mrst_req_addr", 128'(imem_req_addr), 128'(32'h100));
      chk("mrst_o_valid", 128'(o_valid), 128'(0));
      chk("mrst_o_inst", o_inst, 128'(0));
      chk("mrst_mod_sel", 128'(o_pc_mod_select), 128'(0));
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("mrst_idle_req", 128'(imem_req_valid), 128'(0));
      @(negedge clk);
      #2;
      chk("mrst_first_req", 128'(imem_req_valid), 128'(1));
      chk("mrst_first_addr", 128'(imem_req_addr), 128'(32'h100));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_group_generator.md
# fetch_group_generator

Front-end stage directly upstream of the instruction FIFO (MultiInputFifoController datapath). It tracks the fetch PC, requests aligned FETCH_WIDTH-instruction groups from instruction memory and holds each returned group until the FIFO accepts it. It presents the group with the slot range (`o_pc_mod_select` .. `o_pc_upperbound`) that the FIFO adds to its tail. On a branch mispredict it redirects the PC and discards any in-flight memory response.

## Interface
- `BW_PC`, 32, PC width in bits (byte address).
- `BW_INST`, 32, instruction width.
- `FETCH_WIDTH`, 4, instructions per group; power of two, ≥2.
- `BW_PC_MOD`, $clog2(FETCH_WIDTH), slot index width (derived).
- `RESET_PC`, 0, first fetch address.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-low.
- `i_flush` input 1: mispredict redirect (branch valid && !correct prediction).
- `i_flush_pc` input BW_PC: redirect target; bits [1:0] ignored.
- `imem_req_valid` output 1: group request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_req_addr` output BW_PC: group-aligned address, low BW_PC_MOD+2 bits zero.
- `imem_resp_valid` input 1: response for the oldest accepted request.
- `imem_resp_data` input FETCH_WIDTH*BW_INST: slot k at bits [k*BW_INST +: BW_INST].
- `o_valid` output 1: group valid to FIFO.
- `o_ready` input 1: FIFO ready.
- `o_inst` output FETCH_WIDTH*BW_INST: held group.
- `o_pc` output BW_PC: group-aligned base PC.
- `o_pc_mod_select` output BW_PC_MOD: first valid slot, = fetch PC[BW_PC_MOD+1:2].
- `o_pc_upperbound` output BW_PC_MOD: last valid slot, constant FETCH_WIDTH-1.

## Operation
- Registers: `state`, `pc` (BW_PC), `inst_q`.
- FSM states:
  - S_IDLE: reset state; unconditionally → S_REQ next cycle.
  - S_REQ: `imem_req_valid = !i_flush`. Flush → pc←i_flush_pc, stay. Else if `imem_req_ready` → S_WAIT.
  - S_WAIT: flush with `imem_resp_valid` → discard response, pc←i_flush_pc, → S_REQ. Flush alone → pc←i_flush_pc, → S_DRAIN. `imem_resp_valid` alone → inst_q←data, → S_HOLD.
  - S_DRAIN: `imem_resp_valid` → discard, → S_REQ. A further flush here → pc←i_flush_pc, state unchanged.
  - S_HOLD: `o_valid = !i_flush`. Flush → pc←i_flush_pc, → S_REQ, group dropped. `o_ready` && !flush → pc←next_pc, → S_REQ.
- `next_pc = {pc[BW_PC-1:BW_PC_MOD+2] + 1, zeros}`, modulo 2^BW_PC; 0xFFFFFFF0 → 0x0 for defaults.
- `imem_req_addr` = `o_pc` = pc with low BW_PC_MOD+2 bits cleared.
- Number of instructions handed to the FIFO is `o_pc_upperbound - o_pc_mod_select + 1`. Slots below mod_select are present in `o_inst` but unused.
- Only one request is outstanding at a time. `imem_resp_valid` in S_IDLE/S_REQ/S_HOLD is a protocol violation: ignored, assertion fires.
- Flush has priority over every other event in every state.

## Timing
- Reset values: state=S_IDLE, pc=RESET_PC, inst_q=0. All outputs are 0 during reset except `o_pc_upperbound` (constant) and `imem_req_addr`/`o_pc` (aligned RESET_PC).
- First `imem_req_valid` is in the second cycle after reset deassertion.
- Latency: request accepted in cycle t, response at t+k (k≥1), `o_valid` at t+k+1. Next request at earliest the cycle after FIFO acceptance. Peak rate is one group per 3 cycles.
- `o_valid`, `o_inst`, `o_pc` and `o_pc_mod_select` are stable while `o_valid && !o_ready`.
- `o_valid` and `imem_req_valid` depend combinationally on `i_flush`. No other combinational input→output paths exist.
- A redirect takes effect the following cycle. The first request to the target address is issued in the cycle after the flush (from S_REQ/S_HOLD), or after the squashed response drains.
- Mid-operation reset returns to S_IDLE asynchronously. Any in-flight memory response is the memory's responsibility to cancel.

## Test plan
- Reset, RESET_PC=0x100, memory always ready, 1-cycle response → requests 0x100, 0x110, 0x120; each group has mod_select=0, upperbound=3, `o_valid` 3 cycles apart.
- In S_HOLD, flush to 0x208 → `o_valid` low that cycle; next request addr 0x200, `o_pc`=0x200, `o_pc_mod_select`=2 (FIFO adds 2).
- Flush in S_WAIT, response 3 cycles later → response discarded, no `o_valid`; request to flush target issued the cycle after the response.
- Flush in the same cycle as `imem_resp_valid` → data dropped, S_REQ next cycle, request to new target.
- Hold `o_ready` low 5 cycles in S_HOLD → `o_inst`/`o_pc` unchanged, no new `imem_req_valid`; release → pc advances by 16.
- pc=0xFFFFFFF0 group accepted → next `imem_req_addr`=0x00000000.
